// File: rtl/uart_frame_decoder.sv
// Framed-packet extractor for the uart_rx byte stream: SOF, LEN, payload, XOR checksum.
// Payload is held until the checksum verifies, then drained downstream over valid/ready.
module uart_frame_decoder #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = 8'h7E,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_ovf,
    output logic       err_tmo
);

    localparam int IDX_W     = $clog2(MAX_LEN + 1);
    // Buffer depth is rounded up so every index value addresses a real entry.
    localparam int BUF_DEPTH = 1 << IDX_W;
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   len_r, len_n;
    logic [IDX_W-1:0]   wr_idx_r, wr_idx_n;
    logic [IDX_W-1:0]   rd_idx_r, rd_idx_n;
    logic [IDX_W-1:0]   len_last_s;
    logic [7:0]         chk_r, chk_n;
    logic [TMO_W-1:0]   tmo_cnt_r, tmo_n;
    logic [7:0]         mem_r [BUF_DEPTH];
    logic               buf_we_s;
    logic               in_frame_s;
    logic               tmo_hit_s;

    logic [7:0] out_data_r, out_data_n;
    logic       out_valid_r, out_valid_n;
    logic       out_last_r, out_last_n;
    logic       frame_ok_r, frame_ok_n;
    logic       err_chk_r, err_chk_n;
    logic       err_len_r, err_len_n;
    logic       err_ovf_r, err_ovf_n;
    logic       err_tmo_r, err_tmo_n;

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign frame_ok  = frame_ok_r;
    assign err_chk   = err_chk_r;
    assign err_len   = err_len_r;
    assign err_ovf   = err_ovf_r;
    assign err_tmo   = err_tmo_r;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n     = state_r;
        len_n       = len_r;
        chk_n       = chk_r;
        wr_idx_n    = wr_idx_r;
        rd_idx_n    = rd_idx_r;
        buf_we_s    = 1'b0;
        frame_ok_n  = 1'b0;
        err_chk_n   = 1'b0;
        err_len_n   = 1'b0;
        err_ovf_n   = 1'b0;
        err_tmo_n   = 1'b0;
        len_last_s  = len_r - IDX_W'(1);
        in_frame_s  = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
        tmo_hit_s   = in_frame_s && (tmo_cnt_r == TMO_LAST);

        if (!in_frame_s || rx_valid) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo_cnt_r + TMO_W'(1);
        end

        // A timeout wins over a byte arriving in the same cycle; that byte is discarded.
        if (tmo_hit_s) begin
            state_n   = ST_IDLE;
            err_tmo_n = 1'b1;
            tmo_n     = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SOF_BYTE)) begin
                        state_n = ST_LEN;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                            err_len_n = 1'b1;
                            state_n   = ST_IDLE;
                        end else begin
                            len_n    = rx_data[IDX_W-1:0];
                            chk_n    = rx_data;
                            wr_idx_n = '0;
                            state_n  = ST_PAYLOAD;
                        end
                    end else begin
                        state_n = ST_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        buf_we_s = 1'b1;
                        chk_n    = chk_update(chk_r, rx_data);
                        wr_idx_n = wr_idx_r + IDX_W'(1);
                        if (wr_idx_r == len_last_s) begin
                            state_n = ST_CHK;
                        end else begin
                            state_n = ST_PAYLOAD;
                        end
                    end else begin
                        state_n = ST_PAYLOAD;
                    end
                end
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_r) begin
                            rd_idx_n = '0;
                            state_n  = ST_DRAIN;
                        end else begin
                            err_chk_n = 1'b1;
                            state_n   = ST_IDLE;
                        end
                    end else begin
                        state_n = ST_CHK;
                    end
                end
                ST_DRAIN: begin
                    if (rx_valid) begin
                        err_ovf_n = 1'b1;
                    end else begin
                        err_ovf_n = 1'b0;
                    end
                    if (out_valid_r && out_ready) begin
                        if (rd_idx_r == len_last_s) begin
                            frame_ok_n = 1'b1;
                            state_n    = ST_IDLE;
                        end else begin
                            rd_idx_n = rd_idx_r + IDX_W'(1);
                            state_n  = ST_DRAIN;
                        end
                    end else begin
                        state_n = ST_DRAIN;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered, so they are decoded from the upcoming state and read index.
        if (state_n == ST_DRAIN) begin
            out_valid_n = 1'b1;
            out_data_n  = mem_r[rd_idx_n];
            out_last_n  = (rd_idx_n == len_last_s);
        end else begin
            out_valid_n = 1'b0;
            out_data_n  = 8'h00;
            out_last_n  = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            chk_r       <= 8'h00;
            wr_idx_r    <= '0;
            rd_idx_r    <= '0;
            tmo_cnt_r   <= '0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            frame_ok_r  <= 1'b0;
            err_chk_r   <= 1'b0;
            err_len_r   <= 1'b0;
            err_ovf_r   <= 1'b0;
            err_tmo_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            len_r       <= len_n;
            chk_r       <= chk_n;
            wr_idx_r    <= wr_idx_n;
            rd_idx_r    <= rd_idx_n;
            tmo_cnt_r   <= tmo_n;
            out_data_r  <= out_data_n;
            out_valid_r <= out_valid_n;
            out_last_r  <= out_last_n;
            frame_ok_r  <= frame_ok_n;
            err_chk_r   <= err_chk_n;
            err_len_r   <= err_len_n;
            err_ovf_r   <= err_ovf_n;
            err_tmo_r   <= err_tmo_n;
        end
    end

    // Payload buffer; contents need no reset since reads only follow a verified fill.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            mem_r[wr_idx_r] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected bytes and pulse events,
// a negedge monitor pops and compares whatever the decoder presents.
module tb_uart_frame_decoder;

    localparam int EV_OK  = 0;
    localparam int EV_CHK = 1;
    localparam int EV_LEN = 2;
    localparam int EV_OVF = 3;
    localparam int EV_TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_ovf;
    logic       err_tmo;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    int         ev_q[$];

    uart_frame_decoder #(
        .MAX_LEN(16),
        .SOF_BYTE(8'h7E),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .frame_ok(frame_ok),
        .err_chk(err_chk),
        .err_len(err_len),
        .err_ovf(err_ovf),
        .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(exp_q.size() == 0 && ev_q.size() == 0, name, exp_q.size() + ev_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({out_data, out_valid, out_last, frame_ok, err_chk, err_len, err_ovf, err_tmo} == 15'd0,
              name, {out_data, out_valid, out_last, frame_ok, err_chk, err_len, err_ovf, err_tmo}, 0);
    endtask

    // Monitor: handshakes, stall stability, idle output values and pulse events.
    initial begin
        logic       stall_prev;
        logic [8:0] held;
        logic [4:0] p;
        logic [4:0] prev_p;
        logic [8:0] e;
        int         code;
        stall_prev = 1'b0;
        held = 9'd0;
        prev_p = 5'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                prev_p = 5'd0;
            end else begin
                if (stall_prev) begin
                    check(out_valid && ({out_last, out_data} == held), "stall_stable",
                          {out_valid, out_last, out_data}, {1'b1, held});
                end
                if (!out_valid) begin
                    check({out_last, out_data} == 9'd0, "idle_outputs", {out_last, out_data}, 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_byte", {out_last, out_data}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({out_last, out_data} == e, "out_byte", {out_last, out_data}, e);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = {out_last, out_data};
                p = {err_tmo, err_ovf, err_len, err_chk, frame_ok};
                if (p != 5'd0) begin
                    check($countones(p) == 1, "pulse_exclusive", p, 0);
                    check((p & prev_p) == 5'd0, "pulse_width", p & prev_p, 0);
                    code = 0;
                    for (int i = 0; i < 5; i++) begin
                        if (p[i]) code = i;
                    end
                    if (ev_q.size() == 0) begin
                        check(1'b0, "unexpected_event", code, 0);
                    end else begin
                        check(code == ev_q[0], "event", code, ev_q[0]);
                        void'(ev_q.pop_front());
                    end
                end
                prev_p = p;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic [7:0] pay;
        int         k;

        // Reset state
        idle(3);
        rst = 1'b0;
        check_all_zero("reset_outputs");

        // 1: basic good frame, latency and throughput
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        check(out_valid == 1'b1, "latency_valid", out_valid, 1);
        idle(3);
        check(frame_ok == 1'b1, "throughput_frame_ok", frame_ok, 1);
        wait_drain("drain_t1");

        // 2: bad checksum, then a good frame
        ev_q.push_back(EV_CHK);
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h04);
        idle(5);
        push_exp(8'hA5, 1'b0); push_exp(8'h5A, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hFD);
        wait_drain("drain_t2");

        // 3: LEN=0 and LEN=17, trailing bytes ignored; then SOF-as-data and LEN=MAX_LEN
        ev_q.push_back(EV_LEN);
        send_byte(8'h7E); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        ev_q.push_back(EV_LEN);
        send_byte(8'h7E); send_byte(8'h11); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(3);
        push_exp(8'h7E, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        wait_drain("drain_t3a");
        c = 8'h10;
        send_byte(8'h7E); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            pay = 8'(i * 17 + 3);
            c = c ^ pay;
            push_exp(pay, i == 15);
            send_byte(pay);
        end
        ev_q.push_back(EV_OK);
        send_byte(c);
        wait_drain("drain_t3b");

        // 4: stalled drain with an overrun byte, then toggling ready
        out_ready = 1'b0;
        push_exp(8'h01, 1'b0); push_exp(8'h02, 1'b0); push_exp(8'h03, 1'b0); push_exp(8'h04, 1'b1);
        ev_q.push_back(EV_OVF);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h55);
            else idle(1);
        end
        check(out_data == 8'h01, "stall_data", out_data, 8'h01);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            out_ready = ~out_ready;
            idle(1);
        end
        out_ready = 1'b1;
        wait_drain("drain_t4");

        // 5: inter-byte timeout
        ev_q.push_back(EV_TMO);
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
        k = 0;
        while (!err_tmo && k < 80) begin
            idle(1);
            k++;
        end
        check(k == 50, "timeout_cycles", k, 50);
        push_exp(8'h42, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        wait_drain("drain_t5");

        // 6: reset mid-payload and mid-drain
        send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_all_zero("rst_mid_payload");
        push_exp(8'h99, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h99); send_byte(8'h98);
        wait_drain("drain_t6a");
        out_ready = 1'b0;
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
        idle(2);
        check(out_valid == 1'b1, "pre_reset_drain", out_valid, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_all_zero("rst_mid_drain");
        out_ready = 1'b1;
        push_exp(8'h10, 1'b0); push_exp(8'h20, 1'b1);
        ev_q.push_back(EV_OK);
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
        wait_drain("drain_t6b");

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
